// File: rtl/uart_pkg.sv
// Shared types, defaults and helpers for the memory-mapped UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int unsigned OVS = 16;

  localparam logic [31:0] DEF_DATA_AD = 32'h110001A0;
  localparam logic [31:0] DEF_STAT_AD = 32'h110001A4;
  localparam logic [31:0] DEF_POP_AD  = 32'h110001A8;

  localparam int unsigned ST_NEMPTY = 0;
  localparam int unsigned ST_FULL   = 2;
  localparam int unsigned ST_OVR    = 3;
  localparam int unsigned ST_FERR   = 4;

  // Rounded clocks-per-oversample-tick divider.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + 8 * baud) / (OVS * baud);
  endfunction

endpackage

// File: rtl/mmio_uart_rx_if.sv
// IOBUS slice seen by the UART receiver: address/write strobe in, read data and IRQ out.
interface mmio_uart_rx_if;

  logic [31:0] IOBUS_ADDR;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_RDATA;
  logic        IRQ;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_WR,
    input  IOBUS_RDATA,
    input  IRQ
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_WR,
    output IOBUS_RDATA,
    output IRQ
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees the head slot.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata_c,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  assign w_do_push = i_push && (!o_full_c || i_pop);
  assign w_do_pop  = i_pop && !o_empty_c;

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_rx.sv
// 8N1 UART receiver with a byte FIFO, status/pop registers and a not-empty IRQ on IOBUS.
module mmio_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] DATA_AD    = DEF_DATA_AD,
  parameter logic [31:0] STAT_AD    = DEF_STAT_AD,
  parameter logic [31:0] POP_AD     = DEF_POP_AD
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RX,
  mmio_uart_rx_if.slave bus
);

  localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVS);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  rx_state_t        r_state;
  rx_state_t        w_state_nx;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [DIV_W-1:0] r_div_cnt;
  logic [OS_W-1:0]  r_os_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_ovr;
  logic             r_ferr;
  logic             r_irq;

  logic             w_tick;
  logic             w_div_restart;
  logic             w_os_clr;
  logic             w_os_inc;
  logic             w_bit_clr;
  logic             w_bit_inc;
  logic             w_sample_bit;
  logic             w_push;
  logic             w_ferr_set;
  logic             w_ovr_set;
  logic             w_pop;
  logic             w_stat_wr;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [7:0]       w_head;
  logic [31:0]      w_stat;
  logic [31:0]      w_rdata;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_div_restart = 1'b0;
    w_os_clr      = 1'b0;
    w_os_inc      = 1'b0;
    w_bit_clr     = 1'b0;
    w_bit_inc     = 1'b0;
    w_sample_bit  = 1'b0;
    w_push        = 1'b0;
    w_ferr_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nx    = START;
          w_div_restart = 1'b1;
          w_os_clr      = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(OVS / 2 - 1)) begin
            w_os_clr = 1'b1;
            if (!r_rx_s) begin
              w_state_nx = DATA;
              w_bit_clr  = 1'b1;
            end else begin
              w_state_nx = IDLE;
            end
          end else begin
            w_os_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(OVS - 1)) begin
            w_os_clr     = 1'b1;
            w_sample_bit = 1'b1;
            if (r_bit_idx == 3'd7) begin
              w_state_nx = STOP;
            end else begin
              w_bit_inc = 1'b1;
            end
          end else begin
            w_os_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(OVS - 1)) begin
            w_os_clr = 1'b1;
            if (r_rx_s) begin
              w_push     = 1'b1;
              w_state_nx = IDLE;
            end else begin
              w_ferr_set = 1'b1;
              w_state_nx = BREAK;
            end
          end else begin
            w_os_inc = 1'b1;
          end
        end
      end
      BREAK: begin
        if (r_rx_s) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Free-running tick divider, oversample counter, bit index and shift register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_div_restart || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_os_clr) begin
        r_os_cnt <= '0;
      end else if (w_os_inc) begin
        r_os_cnt <= r_os_cnt + OS_W'(1);
      end
      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_bit_inc) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_sample_bit) begin
        r_shift[r_bit_idx] <= r_rx_s;
      end
    end
  end

  assign w_pop     = bus.IOBUS_WR && (bus.IOBUS_ADDR == POP_AD);
  assign w_stat_wr = bus.IOBUS_WR && (bus.IOBUS_ADDR == STAT_AD);
  assign w_ovr_set = w_push && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (r_shift),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  // Sticky error flags: a same-cycle set beats a clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (w_stat_wr) begin
        r_ovr <= 1'b0;
      end
      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (w_stat_wr) begin
        r_ferr <= 1'b0;
      end
      r_irq <= (w_count != '0);
    end
  end

  always_comb begin
    w_stat            = '0;
    w_stat[ST_NEMPTY] = !w_empty;
    w_stat[ST_FULL]   = w_full;
    w_stat[ST_OVR]    = r_ovr;
    w_stat[ST_FERR]   = r_ferr;
  end

  always_comb begin
    w_rdata = '0;
    if ((bus.IOBUS_ADDR == DATA_AD) && !w_empty) begin
      w_rdata = {24'b0, w_head};
    end else if (bus.IOBUS_ADDR == STAT_AD) begin
      w_rdata = w_stat;
    end
  end

  assign bus.IOBUS_RDATA = w_rdata;
  assign bus.IRQ         = r_irq;

endmodule

// File: tb/tb_mmio_uart_rx.sv
// Scoreboard bench for mmio_uart_rx: serial frames in, IOBUS status/data/pop checked out.
module tb_mmio_uart_rx;
  import uart_pkg::*;

  // Fast baud keeps the run short; all frame timing scales from DIV.
  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 781_250;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned DIV      = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int unsigned BIT_CLKS = OVS * DIV;
  // Negedges from driving the start bit to the cycle whose posedge samples the stop bit.
  localparam int unsigned STOP_LAG = 2 + DIV * (OVS / 2 + 9 * OVS);

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic RX    = 1'b1;

  mmio_uart_rx_if bus ();

  mmio_uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH),
    .DATA_AD    (DEF_DATA_AD),
    .STAT_AD    (DEF_STAT_AD),
    .POP_AD     (DEF_POP_AD)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .RX    (RX),
    .bus   (bus)
  );

  always #10 CLK = ~CLK;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;
  logic [7:0]  sb_q[$];
  logic        m_ovr  = 1'b0;
  logic        m_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.IOBUS_ADDR = a;
    #1;
    d = bus.IOBUS_RDATA;
  endtask

  task automatic bus_write(input logic [31:0] a);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_WR   = 1'b1;
    @(negedge CLK);
    bus.IOBUS_WR   = 1'b0;
    bus.IOBUS_ADDR = '0;
  endtask

  function automatic logic [31:0] model_stat();
    logic [31:0] s;
    s            = '0;
    s[ST_NEMPTY] = (sb_q.size() != 0);
    s[ST_FULL]   = (sb_q.size() == DEPTH);
    s[ST_OVR]    = m_ovr;
    s[ST_FERR]   = m_ferr;
    return s;
  endfunction

  task automatic check_stat(input string tag);
    logic [31:0] d;
    bus_read(DEF_STAT_AD, d);
    check(tag, d, model_stat());
  endtask

  task automatic check_irq(input string tag);
    check(tag, 32'(bus.IRQ), 32'(sb_q.size() != 0));
  endtask

  // Read the head, compare with the oldest expected byte, then pop it.
  task automatic pop_check(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    bus_read(DEF_DATA_AD, d);
    e = (sb_q.size() != 0) ? {24'b0, sb_q.pop_front()} : 32'h0;
    check(tag, d, e);
    bus_write(DEF_POP_AD);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (sb_q.size() < DEPTH) sb_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    RX = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      idle(BIT_CLKS);
    end
    RX = stop;
    idle(BIT_CLKS);
  endtask

  initial begin
    logic [31:0] rd;
    bus.IOBUS_ADDR = '0;
    bus.IOBUS_WR   = 1'b0;

    idle(3);
    check_stat("rst_stat");
    check_irq("rst_irq");
    bus_read(DEF_DATA_AD, rd);
    check("rst_data", rd, 32'h0);
    RST_N = 1'b1;
    idle(2);

    // Single byte, other addresses read zero, pop clears it.
    send_frame(8'hA5, 1'b1);
    idle(4);
    check_stat("a5_stat");
    check_irq("a5_irq");
    bus_read(DEF_POP_AD, rd);
    check("pop_ad_reads0", rd, 32'h0);
    bus_read(32'h1100_0000, rd);
    check("other_ad_reads0", rd, 32'h0);
    pop_check("a5_data");
    idle(2);
    check_stat("a5_pop_stat");
    check_irq("a5_pop_irq");
    bus_read(DEF_DATA_AD, rd);
    check("a5_pop_data", rd, 32'h0);

    // Short low glitch is rejected.
    RX = 1'b0;
    idle(4 * DIV);
    RX = 1'b1;
    idle(BIT_CLKS * 11);
    check_stat("glitch_stat");
    check_irq("glitch_irq");

    // Overfill by one, then drain in order.
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    idle(4);
    check_stat("ovf_stat");
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf_pop%0d", i));
    idle(2);
    check_stat("ovf_drained_stat");
    bus_write(DEF_STAT_AD);
    m_ovr = 1'b0;
    check_stat("ovf_cleared_stat");
    bus_write(DEF_POP_AD);
    idle(2);
    check_stat("empty_pop_stat");
    bus_read(DEF_DATA_AD, rd);
    check("empty_pop_data", rd, 32'h0);

    // Framing error with a STAT clear landing on the set cycle, then a long break.
    fork
      send_frame(8'h3C, 1'b0);
      begin
        idle(STOP_LAG);
        bus_write(DEF_STAT_AD);
      end
    join
    idle(4);
    check_stat("ferr_set_wins");
    check_irq("ferr_irq");
    bus_write(DEF_STAT_AD);
    m_ferr = 1'b0;
    idle(2000);
    check_stat("break_single_ferr");
    RX = 1'b1;
    idle(BIT_CLKS);
    check_stat("break_release_stat");

    // Fill, then pop on the exact cycle the next byte is pushed.
    for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 1'b1);
    idle(4);
    check_stat("full_stat");
    bus_read(DEF_DATA_AD, rd);
    check("full_head", rd, {24'b0, sb_q[0]});
    void'(sb_q.pop_front());
    fork
      send_frame(8'hC7, 1'b1);
      begin
        idle(STOP_LAG);
        bus_write(DEF_POP_AD);
      end
    join
    idle(4);
    check_stat("full_pushpop_stat");
    for (int i = 0; i < 16; i++) pop_check($sformatf("full_pop%0d", i));
    idle(2);
    check_stat("full_drained_stat");

    // Reset pulse during data bit 4 aborts the frame.
    fork
      send_frame(8'hF5, 1'b1);
      begin
        idle(BIT_CLKS * 5 + BIT_CLKS / 2);
        RST_N = 1'b0;
        idle(1);
        RST_N = 1'b1;
      end
    join
    sb_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    idle(BIT_CLKS);
    check_stat("midrst_stat");
    check_irq("midrst_irq");
    send_frame(8'h5A, 1'b1);
    idle(4);
    check_stat("after_rst_stat");
    check_irq("after_rst_irq");
    pop_check("after_rst_data");
    idle(2);
    check_stat("final_stat");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
